fetch_pair_queue: RTL and testbench

- Dual-issue instruction queue between fetch and the two-lane decode stage. Feeds the decode inputs instrd/instrd2 and pcplus4d/pcplus4d2.
- Fetch pushes 0-2 instructions per cycle. The hazard/issue logic pops 0-2 per cycle.
- Head entries are presented show-ahead to lane 1 (oldest) and lane 2 (next oldest).
- Decouples fetch from decode stalls and discards wrong-path instructions on branch redirect.

---
 rtl/fetch_pair_queue_if.sv | 31 +++
 rtl/fetch_pair_queue.sv | 112 +++++++++++
 tb/tb_fetch_pair_queue.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/fetch_pair_queue_if.sv
// Fetch-to-decode handshake bundle for the dual-issue instruction queue.
// The master side is fetch plus the issue logic; the slave side is the queue.
interface fetch_pair_queue_if #(
   parameter int AW = 3
);
   logic [1:0]  push_cnt;
   logic [31:0] in_instr0;
   logic [31:0] in_instr1;
   logic [31:0] in_pcplus4;
   logic        in_ready;
   logic [1:0]  issue_cnt;
   logic        flush;
   logic [31:0] instrd;
   logic [31:0] instrd2;
   logic [31:0] pcplus4d;
   logic [31:0] pcplus4d2;
   logic        validd;
   logic        validd2;
   logic [AW:0] count;
   logic        err;

   modport master (
      output push_cnt, in_instr0, in_instr1, in_pcplus4, issue_cnt, flush,
      input  in_ready, instrd, instrd2, pcplus4d, pcplus4d2, validd, validd2, count, err
   );

   modport slave (
      input  push_cnt, in_instr0, in_instr1, in_pcplus4, issue_cnt, flush,
      output in_ready, instrd, instrd2, pcplus4d, pcplus4d2, validd, validd2, count, err
   );
endinterface

// File: rtl/fetch_pair_queue.sv
// Dual-issue instruction queue between fetch and two-lane decode.
// Head pair is shown ahead to the decode lanes; illegal handshakes set a sticky err.
module fetch_pair_queue #(
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input logic            clk,
   input logic            reset_n,
   fetch_pair_queue_if.slave bus
);

   localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
   localparam logic [AW:0] TWO_W   = (AW+1)'(2);

   logic [31:0]   instr_mem [DEPTH];
   logic [31:0]   pc_mem    [DEPTH];

   logic [AW-1:0] head;
   logic [AW-1:0] tail;
   logic [AW:0]   count;
   logic          err_q;

   logic [AW-1:0] head1;
   logic [AW-1:0] tail1;
   logic [AW:0]   free;
   logic          ready;
   logic [1:0]    pop;
   logic [1:0]    push;
   logic          pop_err;
   logic          push_err;
   logic [31:0]   pc_second;

   assign head1     = head + AW'(1);
   assign tail1     = tail + AW'(1);
   assign free      = DEPTH_W - count;
   assign ready     = (free >= TWO_W);
   assign pc_second = bus.in_pcplus4 + 32'd4;

   // Pop is clamped to what is actually held; issue_cnt=3 is a no-op.
   always_comb begin
      pop     = 2'd0;
      pop_err = 1'b0;
      if (bus.issue_cnt == 2'd3) begin
         pop_err = 1'b1;
      end else if ((AW+1)'(bus.issue_cnt) > count) begin
         pop     = count[1:0];
         pop_err = 1'b1;
      end else begin
         pop = bus.issue_cnt;
      end
   end

   // in_ready comes from the registered count only, so a full queue drops pushes
   // even when decode pops in the same cycle.
   always_comb begin
      push     = 2'd0;
      push_err = 1'b0;
      if (bus.push_cnt == 2'd3) begin
         push_err = 1'b1;
      end else if (bus.push_cnt != 2'd0 && !ready) begin
         push_err = 1'b1;
      end else begin
         push = bus.push_cnt;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         err_q <= 1'b0;
      end else if (bus.flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         head  <= head + AW'(pop);
         tail  <= tail + AW'(push);
         count <= count + (AW+1)'(push) - (AW+1)'(pop);
         if (pop_err || push_err) begin
            err_q <= 1'b1;
         end
      end
   end

   // Storage carries no reset; occupancy alone decides what is visible.
   always_ff @(posedge clk) begin
      if (reset_n && !bus.flush) begin
         if (push != 2'd0) begin
            instr_mem[tail] <= bus.in_instr0;
            pc_mem[tail]    <= bus.in_pcplus4;
         end
         if (push == 2'd2) begin
            instr_mem[tail1] <= bus.in_instr1;
            pc_mem[tail1]    <= pc_second;
         end
      end
   end

   // Empty lanes present zero, which decodes as a NOP.
   assign bus.validd    = (count >= (AW+1)'(1));
   assign bus.validd2   = (count >= TWO_W);
   assign bus.instrd    = bus.validd  ? instr_mem[head]  : 32'd0;
   assign bus.pcplus4d  = bus.validd  ? pc_mem[head]     : 32'd0;
   assign bus.instrd2   = bus.validd2 ? instr_mem[head1] : 32'd0;
   assign bus.pcplus4d2 = bus.validd2 ? pc_mem[head1]    : 32'd0;
   assign bus.in_ready  = ready;
   assign bus.count     = count;
   assign bus.err       = err_q;

endmodule

// File: tb/tb_fetch_pair_queue.sv
// Scoreboard bench for fetch_pair_queue: a queue-based reference model predicts
// every cycle's outputs, and a negedge monitor compares them against the DUT.
module tb_fetch_pair_queue;

   localparam int DEPTH = 8;
   localparam int AW    = 3;

   typedef struct {
      logic [31:0] instrd;
      logic [31:0] instrd2;
      logic [31:0] pc;
      logic [31:0] pc2;
      int          count;
      bit          v;
      bit          v2;
      bit          rdy;
      bit          err;
   } exp_t;

   logic clk = 1'b0;
   logic reset_n;

   fetch_pair_queue_if #(.AW(AW)) bus ();

   fetch_pair_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [63:0] mq[$];
   bit          err_m = 1'b0;
   exp_t        exp_q[$];

   task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, req, $time);
      end
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         cmp("count",     32'(bus.count), 32'(e.count));
         cmp("validd",    32'(bus.validd), 32'(e.v));
         cmp("validd2",   32'(bus.validd2), 32'(e.v2));
         cmp("in_ready",  32'(bus.in_ready), 32'(e.rdy));
         cmp("err",       32'(bus.err), 32'(e.err));
         cmp("instrd",    bus.instrd, e.instrd);
         cmp("instrd2",   bus.instrd2, e.instrd2);
         cmp("pcplus4d",  bus.pcplus4d, e.pc);
         cmp("pcplus4d2", bus.pcplus4d2, e.pc2);
      end
   end

   // One clock: drive inputs, advance the reference model at the edge, queue the prediction.
   task automatic step(input int pc, input logic [31:0] i0, input logic [31:0] i1,
                       input logic [31:0] p4, input int iss, input bit fl, input bit rs);
      int   cnt;
      int   p;
      int   pu;
      bit   rdy;
      exp_t e;
      reset_n       = rs;
      bus.push_cnt  = 2'(pc);
      bus.in_instr0 = i0;
      bus.in_instr1 = i1;
      bus.in_pcplus4 = p4;
      bus.issue_cnt = 2'(iss);
      bus.flush     = fl;
      @(posedge clk);
      if (!rs) begin
         mq.delete();
         err_m = 1'b0;
      end else if (fl) begin
         mq.delete();
      end else begin
         cnt = mq.size();
         rdy = (DEPTH - cnt) >= 2;
         if (iss == 3) begin p = 0; err_m = 1'b1; end
         else if (iss > cnt) begin p = cnt; err_m = 1'b1; end
         else p = iss;
         if (pc == 3) begin pu = 0; err_m = 1'b1; end
         else if (pc != 0 && !rdy) begin pu = 0; err_m = 1'b1; end
         else pu = pc;
         for (int k = 0; k < p; k++) void'(mq.pop_front());
         if (pu >= 1) mq.push_back({i0, p4});
         if (pu == 2) mq.push_back({i1, p4 + 32'd4});
      end
      e.count   = mq.size();
      e.v       = mq.size() >= 1;
      e.v2      = mq.size() >= 2;
      e.rdy     = (DEPTH - mq.size()) >= 2;
      e.err     = err_m;
      e.instrd  = (mq.size() >= 1) ? mq[0][63:32] : 32'd0;
      e.pc      = (mq.size() >= 1) ? mq[0][31:0]  : 32'd0;
      e.instrd2 = (mq.size() >= 2) ? mq[1][63:32] : 32'd0;
      e.pc2     = (mq.size() >= 2) ? mq[1][31:0]  : 32'd0;
      exp_q.push_back(e);
      #1;
   endtask

   task automatic idle();
      step(0, 32'd0, 32'd0, 32'd0, 0, 1'b0, 1'b1);
   endtask

   initial begin
      int          pc;
      int          iss;
      logic [31:0] ra;
      logic [31:0] rb;
      logic [31:0] rp;

      // Reset then idle
      step(0, 32'd0, 32'd0, 32'd0, 0, 1'b0, 1'b0);
      step(0, 32'd0, 32'd0, 32'd0, 0, 1'b0, 1'b0);
      idle();
      @(negedge clk);
      cmp("rst_count", 32'(bus.count), 32'd0);
      cmp("rst_ready", 32'(bus.in_ready), 32'd1);
      cmp("rst_instrd", bus.instrd, 32'd0);

      // Dual push then dual issue
      step(2, 32'h2008_0005, 32'h2009_0007, 32'h0040_0004, 0, 1'b0, 1'b1);
      @(negedge clk);
      cmp("dp_instrd", bus.instrd, 32'h2008_0005);
      cmp("dp_pcplus4d", bus.pcplus4d, 32'h0040_0004);
      cmp("dp_instrd2", bus.instrd2, 32'h2009_0007);
      cmp("dp_pcplus4d2", bus.pcplus4d2, 32'h0040_0008);
      cmp("dp_count", 32'(bus.count), 32'd2);
      step(0, 32'd0, 32'd0, 32'd0, 2, 1'b0, 1'b1);
      @(negedge clk);
      cmp("di_count", 32'(bus.count), 32'd0);
      cmp("di_validd", 32'(bus.validd), 32'd0);

      // Single issue shift: A,B,C then issue 1
      step(2, 32'hAAAA_0001, 32'hBBBB_0002, 32'h0000_1004, 0, 1'b0, 1'b1);
      step(1, 32'hCCCC_0003, 32'd0, 32'h0000_100C, 0, 1'b0, 1'b1);
      step(0, 32'd0, 32'd0, 32'd0, 1, 1'b0, 1'b1);
      @(negedge clk);
      cmp("si_instrd", bus.instrd, 32'hBBBB_0002);
      cmp("si_instrd2", bus.instrd2, 32'hCCCC_0003);
      cmp("si_count", 32'(bus.count), 32'd2);
      step(0, 32'd0, 32'd0, 32'd0, 2, 1'b0, 1'b1);

      // Fill to full, then push against full with a pop
      for (int i = 0; i < 4; i++) step(2, $urandom, $urandom, $urandom, 0, 1'b0, 1'b1);
      @(negedge clk);
      cmp("full_count", 32'(bus.count), 32'd8);
      cmp("full_ready", 32'(bus.in_ready), 32'd0);
      step(2, $urandom, $urandom, $urandom, 2, 1'b0, 1'b1);
      @(negedge clk);
      cmp("drop_count", 32'(bus.count), 32'd6);
      cmp("drop_err", 32'(bus.err), 32'd1);
      for (int i = 0; i < 20; i++) step(2, $urandom, $urandom, $urandom, 2, 1'b0, 1'b1);

      // Flush priority from count=5
      step(0, 32'd0, 32'd0, 32'd0, 1, 1'b0, 1'b1);
      step(2, $urandom, $urandom, $urandom, 1, 1'b1, 1'b1);
      @(negedge clk);
      cmp("fl_count", 32'(bus.count), 32'd0);
      cmp("fl_ready", 32'(bus.in_ready), 32'd1);

      // Reset mid-operation, then pop clamp
      step(2, $urandom, $urandom, $urandom, 0, 1'b0, 1'b1);
      step(1, $urandom, $urandom, $urandom, 0, 1'b0, 1'b1);
      step(0, 32'd0, 32'd0, 32'd0, 2, 1'b0, 1'b0);
      @(negedge clk);
      cmp("mr_count", 32'(bus.count), 32'd0);
      cmp("mr_err", 32'(bus.err), 32'd0);
      step(1, 32'h1234_5678, 32'd0, 32'h0000_2004, 0, 1'b0, 1'b1);
      step(0, 32'd0, 32'd0, 32'd0, 2, 1'b0, 1'b1);
      @(negedge clk);
      cmp("cl_count", 32'(bus.count), 32'd0);
      cmp("cl_err", 32'(bus.err), 32'd1);

      // Randomized traffic with occasional flush, reset and illegal codes
      for (int i = 0; i < 600; i++) begin
         pc  = ($urandom_range(0, 19) == 0) ? 3 : int'($urandom_range(0, 2));
         iss = ($urandom_range(0, 19) == 0) ? 3 : int'($urandom_range(0, 2));
         ra = $urandom;
         rb = $urandom;
         rp = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : $urandom;
         step(pc, ra, rb, rp, iss, ($urandom_range(0, 29) == 0), ($urandom_range(0, 59) != 0));
      end

      idle();
      repeat (3) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain actual=%0d required=0 pending predictions", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
